// File: rtl/md_sched_if.sv
// E-stage / D-stage interface between the pipeline and the multiply/divide sequencer.
interface md_sched_if;
    logic [2:0]  e_op;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic        e_kill;
    logic        d_is_md;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        md_stall;

    // Pipeline side: presents ops and reads HI/LO plus the stall request.
    modport master (
        output e_op, e_rs, e_rt, e_kill, d_is_md,
        input  hi, lo, busy, md_stall
    );

    // Sequencer side: owns HI/LO and raises the stall request.
    modport slave (
        input  e_op, e_rs, e_rt, e_kill, d_is_md,
        output hi, lo, busy, md_stall
    );
endinterface

// File: rtl/md_sched.sv
// Multiply/divide sequencer for the 5-stage MIPS pipeline.
// Owns HI/LO, models mult/div latency with a 4-bit busy counter and
// requests a D-stage stall whenever a HI/LO instruction in D would race it.
module md_sched #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic      clk,
    input  logic      reset_n,
    md_sched_if.slave bus
);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e      state;
    logic [3:0]  count;
    logic [63:0] pending;
    logic        pend_wr;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy_q;

    md_op_e      eff_op;
    logic        issue_md;
    logic        is_mult;
    logic        signed_div;
    logic        div_zero;
    logic [63:0] ext_rs;
    logic [63:0] ext_rt;
    logic [63:0] product;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [63:0] md_result;

    // Decode the effective E-stage op; killed or reserved ops do nothing.
    always_comb begin
        eff_op   = bus.e_kill ? OP_NONE : md_op_e'(bus.e_op);
        issue_md = eff_op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
        is_mult  = eff_op inside {OP_MULT, OP_MULTU};
    end

    // Result datapath: one 64-bit multiplier and a magnitude divider.
    // Signed divide works on magnitudes so 0x80000000 / -1 cannot overflow.
    always_comb begin
        signed_div = (eff_op == OP_DIV);
        div_zero   = (bus.e_rt == '0);

        if (eff_op == OP_MULT) begin
            ext_rs = {{32{bus.e_rs[31]}}, bus.e_rs};
            ext_rt = {{32{bus.e_rt[31]}}, bus.e_rt};
        end else begin
            ext_rs = {32'd0, bus.e_rs};
            ext_rt = {32'd0, bus.e_rt};
        end
        product = ext_rs * ext_rt;

        rs_mag = (signed_div && bus.e_rs[31]) ? (32'd0 - bus.e_rs) : bus.e_rs;
        rt_mag = (signed_div && bus.e_rt[31]) ? (32'd0 - bus.e_rt) : bus.e_rt;
        if (div_zero) begin
            q_mag = '0;
            r_mag = '0;
        end else begin
            q_mag = rs_mag / rt_mag;
            r_mag = rs_mag % rt_mag;
        end
        quot = (signed_div && (bus.e_rs[31] ^ bus.e_rt[31])) ? (32'd0 - q_mag) : q_mag;
        rem  = (signed_div && bus.e_rs[31]) ? (32'd0 - r_mag) : r_mag;

        md_result = is_mult ? product : {rem, quot};
    end

    // Sequencer FSM: issue into pending, count down, commit HI/LO on the last busy edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            count   <= '0;
            pending <= '0;
            pend_wr <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue_md) begin
                        pending <= md_result;
                        pend_wr <= is_mult || !div_zero;
                        count   <= is_mult ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
                        busy_q  <= 1'b1;
                        state   <= BUSY;
                    end else if (eff_op == OP_MTHI) begin
                        hi_q <= bus.e_rs;
                    end else if (eff_op == OP_MTLO) begin
                        lo_q <= bus.e_rs;
                    end
                end
                BUSY: begin
                    count <= count - 4'd1;
                    if (count <= 4'd1) begin
                        if (pend_wr) begin
                            {hi_q, lo_q} <= pending;
                        end
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
            endcase
        end
    end

    // Flag any op presented while an operation is in flight; it is dropped.
    always_ff @(posedge clk) begin
        if (reset_n && state == BUSY) begin
            assert (eff_op == OP_NONE)
                else $warning("md_sched: op %0d presented while busy, ignored", eff_op);
        end
    end

    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.busy     = busy_q;
    assign bus.md_stall = bus.d_is_md && (busy_q || issue_md);

endmodule

// File: tb/tb_md_sched.sv
// Randomized scoreboard bench for md_sched: a reference model computes HI/LO
// from the architectural rules, completions are checked by a monitor process.
module tb_md_sched;

    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    localparam int OP_MULT  = 1;
    localparam int OP_MULTU = 2;
    localparam int OP_DIV   = 3;
    localparam int OP_DIVU  = 4;
    localparam int OP_MTHI  = 5;
    localparam int OP_MTLO  = 6;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    // Free-running pipeline clock.
    always #5 clk = ~clk;

    md_sched_if mif();

    md_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (mif)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] prev_hi;
        logic [31:0] prev_lo;
        int unsigned cycles;
    } exp_t;

    exp_t        sb_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    bit          mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: new {hi,lo} after op, from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_result(input int op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] h,
                                               input logic [31:0] l);
        longint          sa, sb;
        longint unsigned ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = a;
        ub = b;
        case (op)
            OP_MULT:  return 64'(sa * sb);
            OP_MULTU: return ua * ub;
            OP_DIV:   return (b == 0) ? {h, l} : {32'(sa % sb), 32'(sa / sb)};
            OP_DIVU:  return (b == 0) ? {h, l} : {32'(ua % ub), 32'(ua / ub)};
            OP_MTHI:  return {a, l};
            OP_MTLO:  return {h, a};
            default:  return {h, l};
        endcase
    endfunction

    int unsigned busy_cnt = 0;
    logic        prev_busy = 1'b0;

    // Monitor: checks HI/LO hold during busy and pops the scoreboard when busy falls.
    always @(negedge clk) begin
        exp_t e;
        if (!mon_en) begin
            busy_cnt  = 0;
            prev_busy = 1'b0;
        end else begin
            if (mif.busy) begin
                busy_cnt++;
                if (sb_q.size() == 0) begin
                    check("busy_without_issue", 64'(mif.busy), 64'd0);
                end else begin
                    check("hi_held", 64'(mif.hi), 64'(sb_q[0].prev_hi));
                    check("lo_held", 64'(mif.lo), 64'(sb_q[0].prev_lo));
                end
            end else if (prev_busy) begin
                if (sb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL spurious_completion: got completion, want none at %0t", $time);
                end else begin
                    e = sb_q.pop_front();
                    check("busy_len", 64'(busy_cnt), 64'(e.cycles));
                    check("hi_result", 64'(mif.hi), 64'(e.hi));
                    check("lo_result", 64'(mif.lo), 64'(e.lo));
                end
                busy_cnt = 0;
            end
            prev_busy = mif.busy;
        end
    end

    // Present one op at the current negedge and follow it to completion.
    task automatic run_op(input int op, input logic [31:0] rs, input logic [31:0] rt,
                          input bit dmd, input bit kill, input bit force_busy);
        bit          md_op;
        bit          live;
        logic [63:0] r;
        int unsigned n;
        exp_t        e;
        md_op = (op >= OP_MULT && op <= OP_DIVU);
        live  = !kill && op >= OP_MULT && op <= OP_MTLO;
        mif.e_op    = 3'(op);
        mif.e_rs    = rs;
        mif.e_rt    = rt;
        mif.e_kill  = kill;
        mif.d_is_md = dmd;
        #1;
        check("stall_issue", 64'(mif.md_stall), 64'(dmd && !kill && md_op));
        check("busy_issue", 64'(mif.busy), 64'd0);
        if (live) begin
            r = ref_result(op, rs, rt, m_hi, m_lo);
            if (md_op) begin
                e.hi      = r[63:32];
                e.lo      = r[31:0];
                e.prev_hi = m_hi;
                e.prev_lo = m_lo;
                e.cycles  = (op <= OP_MULTU) ? MC : DC;
                sb_q.push_back(e);
            end
            m_hi = r[63:32];
            m_lo = r[31:0];
        end
        @(negedge clk);
        mif.e_op   = 3'd0;
        mif.e_kill = 1'b0;
        mif.e_rs   = $urandom;
        mif.e_rt   = $urandom;
        if (!(live && md_op)) begin
            #1;
            check("hi_after", 64'(mif.hi), 64'(m_hi));
            check("lo_after", 64'(mif.lo), 64'(m_lo));
            check("busy_idle", 64'(mif.busy), 64'd0);
            check("stall_idle", 64'(mif.md_stall), 64'd0);
        end else begin
            n = (op <= OP_MULTU) ? MC : DC;
            for (int unsigned k = 1; k <= n; k++) begin
                if (k > 1) @(negedge clk);
                if (force_busy && k == 1) begin
                    mif.e_op = 3'(OP_DIV);
                    mif.e_rs = $urandom;
                    mif.e_rt = $urandom_range(1, 9);
                end else if (k == 2) begin
                    mif.e_op = 3'd0;
                end
                #1;
                check("stall_busy", 64'(mif.md_stall), 64'(dmd));
            end
            @(negedge clk);
            mif.e_op = 3'd0;
            #1;
            check("stall_release", 64'(mif.md_stall), 64'd0);
            for (int t = 0; t < 4 && sb_q.size() != 0; t++) @(negedge clk);
            check("sb_drain", 64'(sb_q.size()), 64'd0);
        end
        mif.d_is_md = 1'b0;
    endtask

    // Directed scenarios followed by randomized traffic.
    initial begin
        int          op;
        logic [31:0] rs, rt;
        mif.e_op    = '0;
        mif.e_rs    = '0;
        mif.e_rt    = '0;
        mif.e_kill  = 1'b0;
        mif.d_is_md = 1'b0;
        reset_n     = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_hi", 64'(mif.hi), 64'd0);
        check("reset_lo", 64'(mif.lo), 64'd0);
        check("reset_busy", 64'(mif.busy), 64'd0);
        reset_n = 1'b1;
        mon_en  = 1'b1;
        @(negedge clk);

        // Asynchronous reset between clock edges.
        run_op(OP_MTHI, 32'hA5A5_A5A5, 32'd0, 1'b0, 1'b0, 1'b0);
        run_op(OP_MTLO, 32'h5A5A_5A5A, 32'd0, 1'b0, 1'b0, 1'b0);
        mon_en = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_hi", 64'(mif.hi), 64'd0);
        check("async_reset_lo", 64'(mif.lo), 64'd0);
        check("async_reset_busy", 64'(mif.busy), 64'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        reset_n = 1'b1;

        // Reset while a mult is in flight abandons it.
        @(negedge clk);
        mif.e_op = 3'(OP_MULT);
        mif.e_rs = 32'd3;
        mif.e_rt = 32'd4;
        @(negedge clk);
        mif.e_op = 3'd0;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midop_reset_busy", 64'(mif.busy), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (DC + 2) @(negedge clk);
        check("midop_no_late_hi", 64'(mif.hi), 64'd0);
        check("midop_no_late_lo", 64'(mif.lo), 64'd0);
        check("midop_busy", 64'(mif.busy), 64'd0);
        mon_en = 1'b1;
        @(negedge clk);

        // Directed arithmetic and stall cases.
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        run_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         1'b1, 1'b0, 1'b0);
        run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        run_op(OP_DIVU,  32'd7,         32'd0,         1'b1, 1'b0, 1'b0);
        run_op(OP_MTHI,  32'h1234_5678, 32'd0,         1'b1, 1'b0, 1'b0);
        run_op(OP_MTLO,  32'hDEAD_BEEF, 32'd0,         1'b0, 1'b1, 1'b0);
        run_op(OP_MULT,  32'd3,         32'd4,         1'b0, 1'b0, 1'b0);
        run_op(OP_MULT,  32'hFFFF_FFFB, 32'd7,         1'b1, 1'b0, 1'b0);
        run_op(OP_MULT,  32'h0000_1234, 32'h10,        1'b0, 1'b0, 1'b1);
        run_op(OP_MULT,  32'd9,         32'd9,         1'b1, 1'b1, 1'b0);
        run_op(7,        32'd9,         32'd9,         1'b1, 1'b0, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            op = int'($urandom_range(0, 7));
            rs = ($urandom_range(0, 1) == 1) ? $urandom : 32'($signed($urandom_range(0, 40)) - 20);
            rt = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 1) == 1) ? $urandom
                                                      : 32'($signed($urandom_range(0, 16)) - 8));
            run_op(op, rs, rt, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), 1'b0);
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
